// File: rtl/pit_irq_ctrl.sv
// pit_irq_ctrl: collects interrupt pulses from interval timers, latches them
// as pending bits with saturating per-source miss counters, and presents one
// request at a time to the host through a req/ack handshake, lowest index
// first.
module pit_irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int MISS_W  = 4,
  parameter int ID_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  irq_in,
  input  logic                mask_we,
  input  logic [NUM_SRC-1:0]  mask_data,
  input  logic                clear_all,
  input  logic                ack,
  output logic                irq_out,
  output logic [ID_W-1:0]     irq_id,
  output logic [MISS_W-1:0]   miss_count,
  output logic [NUM_SRC-1:0]  pending
);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] mask;
  logic [MISS_W-1:0]  miss [NUM_SRC];

  logic [NUM_SRC-1:0] evt;
  logic [NUM_SRC-1:0] req;
  logic [ID_W-1:0]    first_id;
  logic               ack_hit;

  assign evt     = irq_in & ~irq_q;
  assign req     = pending & mask;
  assign ack_hit = (state == ASSERT) && ack;

  // Lowest-index enabled pending source
  always_comb begin
    logic found;
    found    = 1'b0;
    first_id = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !found) begin
        found    = 1'b1;
        first_id = ID_W'(i);
      end
    end
  end

  // Input delay register for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= '0;
    else        irq_q <= irq_in;
  end

  // Mask register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mask <= '0;
    else if (mask_we) mask <= mask_data;
  end

  // Pending bits and saturating miss counters; a new event coinciding with
  // the ack of the same source re-arms pending without counting a miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) miss[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (clear_all) begin
          pending[i] <= 1'b0;
          miss[i]    <= '0;
        end else if (ack_hit && (ID_W'(i) == irq_id)) begin
          pending[i] <= evt[i];
          miss[i]    <= '0;
        end else if (evt[i]) begin
          pending[i] <= 1'b1;
          if (pending[i] && (miss[i] != '1)) miss[i] <= miss[i] + MISS_W'(1);
        end
      end
    end
  end

  // Presentation FSM with registered irq_out, irq_id and miss_count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      irq_out    <= 1'b0;
      irq_id     <= '0;
      miss_count <= '0;
    end else if (clear_all) begin
      state      <= IDLE;
      irq_out    <= 1'b0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= ASSERT;
            irq_out    <= 1'b1;
            irq_id     <= first_id;
            miss_count <= miss[first_id];
          end
        end
        ASSERT: begin
          if (ack) begin
            state      <= HOLDOFF;
            irq_out    <= 1'b0;
            miss_count <= '0;
          end else begin
            miss_count <= miss[irq_id];
          end
        end
        HOLDOFF: state <= IDLE;
        default: begin
          state   <= IDLE;
          irq_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pit_irq_ctrl.sv
// Testbench for pit_irq_ctrl: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model.
module tb_pit_irq_ctrl;

  localparam int N    = 4;
  localparam int MW   = 4;
  localparam int IW   = 2;
  localparam int MMAX = (1 << MW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq_in;
  logic          mask_we;
  logic [N-1:0]  mask_data;
  logic          clear_all;
  logic          ack;
  logic          irq_out;
  logic [IW-1:0] irq_id;
  logic [MW-1:0] miss_count;
  logic [N-1:0]  pending;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int m_prev [N];
  int m_pend [N];
  int m_miss [N];
  int m_mask [N];
  int m_served;   // -1 when nothing presented
  int m_id;
  int m_cool;
  int m_mc;

  pit_irq_ctrl #(.NUM_SRC(N), .MISS_W(MW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask_we(mask_we),
    .mask_data(mask_data), .clear_all(clear_all), .ack(ack),
    .irq_out(irq_out), .irq_id(irq_id), .miss_count(miss_count),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0; m_pend[i] = 0; m_miss[i] = 0; m_mask[i] = 0;
    end
    m_served = -1; m_id = 0; m_cool = 0; m_mc = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    int old_p [N];
    int old_m [N];
    int ev;
    for (int i = 0; i < N; i++) begin
      old_p[i] = m_pend[i];
      old_m[i] = m_miss[i];
    end
    if (clear_all) begin
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_miss[i] = 0; end
      m_served = -1; m_cool = 0; m_mc = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        ev = (irq_in[i] && m_prev[i] == 0) ? 1 : 0;
        if (m_served == i && ack) begin
          m_pend[i] = ev;
          m_miss[i] = 0;
        end else if (ev == 1) begin
          if (old_p[i] == 1 && m_miss[i] < MMAX) m_miss[i] = m_miss[i] + 1;
          m_pend[i] = 1;
        end
      end
      if (m_served >= 0) begin
        if (ack) begin m_served = -1; m_cool = 1; m_mc = 0; end
        else m_mc = old_m[m_served];
      end else if (m_cool == 1) begin
        m_cool = 0;
      end else begin
        for (int i = N - 1; i >= 0; i--)
          if (old_p[i] == 1 && m_mask[i] == 1) m_served = i;
        if (m_served >= 0) begin
          m_id = m_served;
          m_mc = old_m[m_served];
        end
      end
    end
    if (mask_we) for (int i = 0; i < N; i++) m_mask[i] = mask_data[i];
    for (int i = 0; i < N; i++) m_prev[i] = irq_in[i];
  endtask

  function automatic int m_pend_vec();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_pend[i] == 1) v = v | (1 << i);
    return v;
  endfunction

  // One clock: step model at the edge, compare 1 time unit later
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("pending", int'(pending), m_pend_vec());
    chk("irq_out", int'(irq_out), (m_served >= 0) ? 1 : 0);
    chk("miss_count", int'(miss_count), m_mc);
    if (m_served >= 0) chk("irq_id", int'(irq_id), m_id);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int n = 0;
    while (!irq_out && n < budget) begin cycle(); n++; end
    chk({tag, "_wait"}, int'(irq_out), 1);
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    mask_we = 1'b1; mask_data = v;
    cycle();
    mask_we = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cycle();
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_data = '0;
    clear_all = 1'b0; ack = 1'b0;
    model_reset();
    #12;
    chk("rst_irq_out", int'(irq_out), 0);
    chk("rst_irq_id", int'(irq_id), 0);
    chk("rst_miss", int'(miss_count), 0);
    chk("rst_pending", int'(pending), 0);
    @(negedge clk) rst_n = 1'b1;
    cycles(2);

    // Single pulse on source 2
    write_mask(4'b1111);
    irq_in = 4'b0100; cycle();
    chk("t1_pend", int'(pending), 4'b0100);
    chk("t1_out_early", int'(irq_out), 0);
    irq_in = '0; cycle();
    chk("t1_out", int'(irq_out), 1);
    chk("t1_id", int'(irq_id), 2);
    chk("t1_miss", int'(miss_count), 0);
    cycles(3);
    do_ack();
    chk("t1_ack_pend", int'(pending), 0);
    chk("t1_ack_out", int'(irq_out), 0);
    cycles(3);
    chk("t1_stay", int'(irq_out), 0);

    // Simultaneous sources 1 and 3
    irq_in = 4'b1010; cycle();
    chk("t2_pend", int'(pending), 4'b1010);
    irq_in = '0;
    wait_irq("t2a", 5);
    chk("t2_id1", int'(irq_id), 1);
    do_ack();
    chk("t2_pend_mid", int'(pending), 4'b1000);
    cycle();
    chk("t2_holdoff", int'(irq_out), 0);
    wait_irq("t2b", 5);
    chk("t2_id3", int'(irq_id), 3);
    do_ack();
    chk("t2_pend_end", int'(pending), 0);
    cycles(2);

    // Masked source accumulates misses up to saturation
    write_mask(4'b0000);
    for (int k = 0; k < 20; k++) begin
      irq_in = 4'b0001; cycle();
      irq_in = '0; cycle();
    end
    chk("t3_pend", int'(pending), 4'b0001);
    chk("t3_masked", int'(irq_out), 0);
    write_mask(4'b0001);
    cycle();
    chk("t3_out", int'(irq_out), 1);
    chk("t3_id", int'(irq_id), 0);
    chk("t3_sat", int'(miss_count), 15);
    do_ack();
    chk("t3_clr", int'(pending), 0);
    cycles(3);
    chk("t3_after", int'(miss_count), 0);

    // Held level gives one event; pulse on the ack edge re-arms
    write_mask(4'b1111);
    irq_in = 4'b0001;
    cycles(50);
    chk("t4_out", int'(irq_out), 1);
    chk("t4_miss", int'(miss_count), 0);
    irq_in = '0; cycle();
    irq_in = 4'b0001; ack = 1'b1;
    cycle();
    ack = 1'b0; irq_in = '0;
    chk("t4_rearm", int'(pending), 4'b0001);
    chk("t4_off", int'(irq_out), 0);
    cycles(2);
    chk("t4_re_out", int'(irq_out), 1);
    chk("t4_re_id", int'(irq_id), 0);
    chk("t4_re_miss", int'(miss_count), 0);
    do_ack();
    cycles(2);

    // Asynchronous reset while presenting id 2
    irq_in = 4'b0100; cycle();
    irq_in = '0;
    wait_irq("t5", 5);
    chk("t5_id", int'(irq_id), 2);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_out", int'(irq_out), 0);
    chk("t5_rst_pend", int'(pending), 0);
    chk("t5_rst_id", int'(irq_id), 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    cycle();

    // clear_all while presenting
    write_mask(4'b1111);
    irq_in = 4'b0110; cycle();
    irq_in = '0;
    wait_irq("t6", 5);
    clear_all = 1'b1; cycle();
    clear_all = 1'b0;
    chk("t6_out", int'(irq_out), 0);
    chk("t6_pend", int'(pending), 0);
    cycles(2);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      irq_in    = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      ack       = ($urandom_range(0, 3) == 0);
      mask_we   = ($urandom_range(0, 15) == 0);
      mask_data = N'($urandom_range(0, 15));
      clear_all = ($urandom_range(0, 99) == 0);
      cycle();
    end
    irq_in = '0; ack = 1'b0; mask_we = 1'b0; clear_all = 1'b0;
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
